// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA BRAM controller: run FSM encoding, byte-offset
// shift helper and the cycle-counter saturation value.
package cgra_pkg;

  // Run FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } run_state_e;

  // Cycle_Count sticks at this value instead of wrapping.
  localparam logic [31:0] CycleCountSat = 32'hFFFF_FFFF;

  // Word-to-byte address shift: log2 of the byte lanes per word.
  function automatic int unsigned byte_shift(input int unsigned byte_len);
    return $clog2(byte_len);
  endfunction

endpackage

// File: rtl/bram_port_pipe.sv
// One load/store channel between the PE array and a BRAM port. Address, write
// enable and store data are registered on the way out; load data is registered
// on the way back. Enables are only driven while the run is active.
module bram_port_pipe
  import cgra_pkg::*;
#(
  parameter int unsigned SYS_DWIDTH = 32,
  parameter int unsigned BYTE_LEN   = 4,
  parameter int unsigned AWIDTH     = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_active,
  input  logic [AWIDTH-1:0]     i_addr,
  input  logic                  i_wr,
  input  logic [SYS_DWIDTH-1:0] i_store_data,
  output logic [SYS_DWIDTH-1:0] o_load_data,
  output logic                  o_bram_en,
  output logic [BYTE_LEN-1:0]   o_bram_wen,
  output logic [SYS_DWIDTH-1:0] o_bram_addr,
  output logic [SYS_DWIDTH-1:0] o_bram_wdata,
  input  logic [SYS_DWIDTH-1:0] i_bram_rdata
);

  localparam int unsigned ByteShift = byte_shift(BYTE_LEN);

  logic [SYS_DWIDTH-1:0] w_byte_addr;
  logic [SYS_DWIDTH-1:0] r_addr;
  logic [SYS_DWIDTH-1:0] r_wdata;
  logic [SYS_DWIDTH-1:0] r_load;
  logic [BYTE_LEN-1:0]   r_wen;
  logic                  r_en;

  assign w_byte_addr = SYS_DWIDTH'(i_addr) << ByteShift;

  // Channel registers; address and store data hold while the run is inactive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_load  <= '0;
      r_wen   <= '0;
      r_en    <= 1'b0;
    end else begin
      r_en   <= i_active;
      r_wen  <= i_active ? {BYTE_LEN{i_wr}} : '0;
      r_load <= i_bram_rdata;
      if (i_active) begin
        r_addr  <= w_byte_addr;
        r_wdata <= i_store_data;
      end
    end
  end

  assign o_bram_en    = r_en;
  assign o_bram_wen   = r_wen;
  assign o_bram_addr  = r_addr;
  assign o_bram_wdata = r_wdata;
  assign o_load_data  = r_load;

endmodule

// File: rtl/cgra_bram_ctrl.sv
// Bridge between the SCGRA PE array and NUM_PORTS host-visible BRAM ports. Owns
// the software start/done handshake, a busy watchdog and a run-length counter.
module cgra_bram_ctrl
  import cgra_pkg::*;
#(
  parameter int unsigned SYS_DWIDTH     = 32,
  parameter int unsigned BYTE_LEN       = 4,
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned AWIDTH         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                             Clk,
  input  logic                             Resetn,
  input  logic                             Computation_Start,
  output logic                             Computation_Done,
  output logic                             Timeout,
  output logic [31:0]                      Cycle_Count,
  output logic                             PE_Array_Start,
  input  logic                             PE_Array_Busy,
  input  logic [NUM_PORTS*AWIDTH-1:0]      Cgra_Addr,
  input  logic [NUM_PORTS-1:0]             Cgra_Wr,
  input  logic [NUM_PORTS*SYS_DWIDTH-1:0]  Cgra_Store_Data,
  output logic [NUM_PORTS*SYS_DWIDTH-1:0]  Cgra_Load_Data,
  output logic [NUM_PORTS-1:0]             Bram_En,
  output logic [NUM_PORTS*BYTE_LEN-1:0]    Bram_Wen,
  output logic [NUM_PORTS*SYS_DWIDTH-1:0]  Bram_Addr,
  output logic [NUM_PORTS*SYS_DWIDTH-1:0]  Bram_Data_To_Bram,
  input  logic [NUM_PORTS*SYS_DWIDTH-1:0]  Bram_Data_From_Bram
);

  run_state_e  r_state;
  run_state_e  w_state_d;
  logic        r_start_q;
  logic        r_seen_busy;
  logic        r_timeout;
  logic [31:0] r_cycle_cnt;
  logic        w_start_edge;
  logic        w_watchdog;
  logic        w_busy_done;
  logic        w_active;

  assign w_start_edge = Computation_Start & ~r_start_q;
  assign w_watchdog   = (TIMEOUT_CYCLES != 0) && (r_cycle_cnt == 32'(TIMEOUT_CYCLES));
  assign w_busy_done  = r_seen_busy & ~PE_Array_Busy;
  assign w_active     = (r_state == StStart) || (r_state == StRun);

  // State register plus start history; history resets high so a start held
  // through reset is not mistaken for a new request.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= StIdle;
      r_start_q <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_start_q <= Computation_Start;
    end
  end

  // Next-state logic for the run handshake.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start_edge) w_state_d = StStart;
      StStart: w_state_d = StRun;
      StRun:   if (w_busy_done || w_watchdog) w_state_d = StDone;
      StDone:  if (!Computation_Start) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Run bookkeeping: busy seen, watchdog flag and saturating RUN-cycle counter.
  // The cycle that leaves RUN is not counted.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_seen_busy <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycle_cnt <= '0;
    end else if (r_state == StIdle && w_start_edge) begin
      r_seen_busy <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycle_cnt <= '0;
    end else if (r_state == StRun) begin
      if (PE_Array_Busy) r_seen_busy <= 1'b1;
      if (w_watchdog) r_timeout <= 1'b1;
      if (w_state_d == StRun && r_cycle_cnt != CycleCountSat) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
    end
  end

  assign PE_Array_Start   = (r_state == StStart);
  assign Computation_Done = (r_state == StDone);
  assign Timeout          = r_timeout;
  assign Cycle_Count      = r_cycle_cnt;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    bram_port_pipe #(
      .SYS_DWIDTH (SYS_DWIDTH),
      .BYTE_LEN   (BYTE_LEN),
      .AWIDTH     (AWIDTH)
    ) u_pipe (
      .i_clk        (Clk),
      .i_rst_n      (Resetn),
      .i_active     (w_active),
      .i_addr       (Cgra_Addr[gi*AWIDTH +: AWIDTH]),
      .i_wr         (Cgra_Wr[gi]),
      .i_store_data (Cgra_Store_Data[gi*SYS_DWIDTH +: SYS_DWIDTH]),
      .o_load_data  (Cgra_Load_Data[gi*SYS_DWIDTH +: SYS_DWIDTH]),
      .o_bram_en    (Bram_En[gi]),
      .o_bram_wen   (Bram_Wen[gi*BYTE_LEN +: BYTE_LEN]),
      .o_bram_addr  (Bram_Addr[gi*SYS_DWIDTH +: SYS_DWIDTH]),
      .o_bram_wdata (Bram_Data_To_Bram[gi*SYS_DWIDTH +: SYS_DWIDTH]),
      .i_bram_rdata (Bram_Data_From_Bram[gi*SYS_DWIDTH +: SYS_DWIDTH])
    );
  end

endmodule
